// File: rtl/wb_ram_responder.sv
// wb_ram_responder: single-port 32-bit word RAM on a Wishbone-style bus.
// One request is in flight at a time. Writes commit at the accept edge with
// per-byte lane enables. Reads return the full word with o_wb_ack,
// LATENCY cycles after the strobe is sampled.
//
// Handshake: a strobe is accepted only when it is sampled high while
// o_wb_stall is low (FSM in S_IDLE). o_wb_stall stays high from the cycle
// after the accept through the ack cycle. o_wb_ack is a one-cycle pulse.
// o_wb_data and o_wb_err are valid in the ack cycle. Strobes seen while
// stalled are dropped.
//
// Optional build macro: WB_RAM_RANGE_CHK_EN. When it is defined, a request
// with nonzero address bits above ADDR_WIDTH does not write RAM, reads
// return 0, and o_wb_err is raised with the ack. When it is undefined,
// o_wb_err stays 0 and the upper address bits alias.
module wb_ram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  output logic        o_wb_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("wb_ram_responder: LATENCY must be within 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  // The state register is kept as a plain named signal so that checkers
  // can bind to it.
  state_t state;
  state_t state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic                  accept;
  logic                  ack_enter;
  logic [31:0]           rd_word;

  logic        pend_read;
  logic        pend_err;
  logic [31:0] pend_word;

  assign idx = i_wb_addr[ADDR_WIDTH-1:0];

`ifdef WB_RAM_RANGE_CHK_EN
  assign in_range = ~|i_wb_addr[31:ADDR_WIDTH];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |i_wb_addr[31:ADDR_WIDTH];
  assign in_range = 1'b1;
`endif

  assign accept     = (state == S_IDLE) && i_wb_stb;
  assign ack_enter  = (state_nxt == S_ACK) && (state != S_ACK);
  assign rd_word    = in_range ? mem[idx] : 32'h0;
  assign o_wb_ack   = (state == S_ACK);
  assign o_wb_stall = (state != S_IDLE);

  // State and latency counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: LATENCY=1 goes straight to S_ACK; otherwise count down in S_WAIT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (i_wb_stb) begin
          if (LATENCY == 1) begin
            state_nxt = S_ACK;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_ACK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Byte-lane write at the accept edge. Reset blocks a coincident strobe.
  always_ff @(posedge i_clk) begin
    if (!i_reset && accept && i_wb_we && in_range) begin
      for (int n = 0; n < 4; n++) begin
        if (i_wb_sel[n]) begin
          mem[idx][8*n +: 8] <= i_wb_data[8*n +: 8];
        end
      end
    end
  end

  // Capture the request at accept, then load the read data and error on entry to S_ACK.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_data <= 32'h0;
      o_wb_err  <= 1'b0;
      pend_read <= 1'b0;
      pend_err  <= 1'b0;
      pend_word <= 32'h0;
    end else begin
      o_wb_err <= 1'b0;
      if (accept) begin
        pend_read <= ~i_wb_we;
        pend_err  <= ~in_range;
        pend_word <= rd_word;
      end
      if (ack_enter) begin
        if (state == S_IDLE) begin
          if (!i_wb_we) begin
            o_wb_data <= rd_word;
          end
          o_wb_err <= ~in_range;
        end else begin
          if (pend_read) begin
            o_wb_data <= pend_word;
          end
          o_wb_err <= pend_err;
        end
      end
    end
  end

endmodule

// File: doc/wb_ram_responder.md
Name: wb_ram_responder

Overview:
- Wishbone-style single-port word RAM responder: the memory end of the bus the CPU memory controller initiates.
- Accepts one single-cycle strobe at a time and applies byte-lane writes from a 4-bit select.
- Returns full 32-bit read words after a programmable latency, with stall and a one-cycle ack.
- Sits between the CPU memory controller and on-chip block RAM; also usable as a memory model in benches.

Parameters:
- ADDR_WIDTH, 10, number of word-address bits; depth = 2**ADDR_WIDTH 32-bit words.
- LATENCY, 1, cycles from strobe sample to ack. Legal range 1..15; an out-of-range value raises $error at elaboration.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_wb_stb  input  1  request strobe, single-cycle pulse.
- i_wb_we  input  1  1 = write, 0 = read.
- i_wb_addr  input  32  word address; bits [ADDR_WIDTH-1:0] index the RAM.
- i_wb_data  input  32  write data; only lanes enabled in i_wb_sel are used.
- i_wb_sel  input  4  byte-lane enables; bit n enables data[8n+7:8n].
- o_wb_ack  output  1  one-cycle completion pulse.
- o_wb_stall  output  1  high while a request is in flight; new strobes are not accepted.
- o_wb_data  output  32  read data, valid from the ack cycle onward.
- o_wb_err  output  1  error flag, valid with ack. Tied 0 unless WB_RAM_RANGE_CHK_EN is defined.

Behaviour:
- Reset (i_clk, i_reset synchronous active-high):
  - o_wb_ack=0, o_wb_stall=0, o_wb_data=0, o_wb_err=0, state=S_IDLE, latency counter=0.
  - RAM contents are not cleared.
- States: S_IDLE, S_WAIT, S_ACK.
- Accept:
  - In S_IDLE, i_wb_stb=1 sampled at the end of cycle c accepts the request.
  - Write: each lane with sel[n]=1 is written at that same edge; lanes with sel[n]=0 keep old contents; sel=0000 writes nothing but is still acked.
  - Read: the full word at the address is captured at that edge, and sel is ignored. o_wb_data updates to the captured word at the start of the ack cycle.
- Timing:
  - o_wb_ack=1 for exactly cycle c+LATENCY.
  - o_wb_stall=1 for cycles c+1 .. c+LATENCY inclusive (the ack cycle included), and 0 from c+LATENCY+1.
  - Earliest next accept is a strobe in cycle c+LATENCY+1.
- Transitions:
  - LATENCY=1: S_IDLE -> S_ACK -> S_IDLE.
  - LATENCY>1: S_IDLE -> S_WAIT (counter loads LATENCY-2, decrements each cycle; at 0 go to S_ACK) -> S_ACK -> S_IDLE.
- Output hold:
  - o_wb_data holds its value between read acks and is not changed by write acks.
  - o_wb_err is cleared in the cycle after ack.
- Strobes while stalled (S_WAIT/S_ACK) are ignored: no write, no ack, no state change. The initiator must not issue them.
- i_wb_we, i_wb_addr, i_wb_data and i_wb_sel are sampled only at the accept edge and need not be held afterwards.
- Reset mid-operation: the in-flight transaction is abandoned with no ack, and state returns to S_IDLE. A write already committed at the accept edge remains in RAM.
- Reset has priority over a simultaneous strobe: the strobe is not accepted.
- Without the optional feature, address bits [31:ADDR_WIDTH] are ignored, so addresses alias modulo the depth.

Optional Feature:
- WB_RAM_RANGE_CHK_EN, defined:
  - An accepted request with any nonzero bit in i_wb_addr[31:ADDR_WIDTH] is out of range.
  - Out-of-range write: nothing is written.
  - Out-of-range read: the word loaded into o_wb_data is 0.
  - Ack timing is unchanged, and o_wb_err=1 in the ack cycle.
- WB_RAM_RANGE_CHK_EN, undefined: o_wb_err is constant 0 and upper address bits alias as described above.

Test Plan:
- Reset, LATENCY=1:
  - Write addr 5, data 0xDEADBEEF, sel 1111 -> ack exactly 1 cycle after stb, stall high only in that cycle.
  - Read addr 5 -> ack next cycle with o_wb_data=0xDEADBEEF.
- Byte lanes:
  - Write 0x11223344 sel 1111 to addr 3, then 0xAABBCCDD sel 0101 -> read addr 3 returns 0x11BB33DD.
  - Write with sel 0000 -> ack, contents unchanged.
- LATENCY=4:
  - Read stb in cycle 10 -> stall high cycles 11..14, ack only cycle 14.
  - Extra stb in cycle 12 with we=1 -> ignored, no second ack, RAM unchanged.
  - Next stb accepted in cycle 15.
- Reset in cycle 12 of a LATENCY=4 write accepted in cycle 10 -> no ack, stall=0 from cycle 13.
  - Subsequent read of that address returns the written data.
- Aliasing, ADDR_WIDTH=10, macro undefined:
  - Write 0xCAFEF00D to addr 0x405 -> read addr 0x005 returns 0xCAFEF00D, o_wb_err=0.
- Range check, macro defined:
  - Write to addr 0x405 -> ack with o_wb_err=1; a read of addr 0x005 afterwards is unchanged.
  - Read addr 0x405 -> o_wb_data=0, o_wb_err=1 in the ack cycle, 0 in the next cycle.
